// File: rtl/lisa_rx_os_fifo.sv
// UART 8N1 receiver: oversampled majority-vote bit sampling feeding a small show-ahead FIFO.
// Optional break detection is compiled in when LISA_RX_BREAK_DET_EN is defined.
module lisa_rx_os_fifo #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_ref,
    input  logic       rxd,
    input  logic       rd,
    input  logic       clr_err,
    output logic [7:0] d,
    output logic       data_avail,
    output logic [4:0] fifo_level,
    output logic       frame_err,
    output logic       overrun,
    output logic       break_det
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] T_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] T_MIDM2 = CW'(OVERSAMPLE / 2 - 2);
    localparam logic [CW-1:0] T_MIDM1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] T_MID   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] T_MIDP1 = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic          rxd_meta, rxd_s;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shreg, shreg_n;
    logic [1:0]    ones, ones_n;
    logic          armed, armed_n;
    logic          vote;
    logic          push_ev, frame_ev, push_q;
`ifdef LISA_RX_BREAK_DET_EN
    logic          break_ev;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            ones    <= '0;
            armed   <= 1'b1;
            push_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shreg   <= shreg_n;
            ones    <= ones_n;
            armed   <= armed_n;
            push_q  <= push_ev;
        end
    end

    // Third sample is the live input on the decision tick; two earlier ones are counted.
    assign vote = ones[1] | (ones[0] & rxd_s);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bit_n    = bit_idx;
        shreg_n  = shreg;
        ones_n   = ones;
        armed_n  = armed;
        push_ev  = 1'b0;
        frame_ev = 1'b0;
`ifdef LISA_RX_BREAK_DET_EN
        break_ev = 1'b0;
`endif
        if (baud_ref) begin
            cnt_n = cnt + CW'(1);
            case (state)
                IDLE: begin
                    cnt_n  = '0;
                    ones_n = '0;
                    if (!armed) begin
                        if (rxd_s) armed_n = 1'b1;
                    end else if (!rxd_s) begin
                        state_n = START;
                    end
                end
                START: begin
                    if (cnt == T_MIDM2 || cnt == T_MIDM1) ones_n = ones + {1'b0, rxd_s};
                    if (cnt == T_MID && vote) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (cnt == T_LAST) begin
                        state_n = DATA;
                        cnt_n   = '0;
                        ones_n  = '0;
                        bit_n   = '0;
                    end
                end
                DATA: begin
                    if (cnt == T_MIDM1 || cnt == T_MID) ones_n = ones + {1'b0, rxd_s};
                    if (cnt == T_MIDP1) begin
                        shreg_n = {vote, shreg[7:1]};
                        ones_n  = '0;
                    end
                    if (cnt == T_LAST) begin
                        cnt_n = '0;
                        if (bit_idx == 3'd7) state_n = STOP;
                        else                 bit_n   = bit_idx + 3'd1;
                    end
                end
                STOP: begin
                    if (cnt == T_MIDM1 || cnt == T_MID) ones_n = ones + {1'b0, rxd_s};
                    if (cnt == T_MIDP1) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        ones_n  = '0;
                        if (vote) begin
                            push_ev = 1'b1;
                        end else begin
                            armed_n = 1'b0;
`ifdef LISA_RX_BREAK_DET_EN
                            if (shreg == 8'h00) break_ev = 1'b1;
                            else                frame_ev = 1'b1;
`else
                            frame_ev = 1'b1;
`endif
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    logic [7:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, level;
    logic        empty, full, do_pop, do_wr, ovr_ev;

    assign level  = wr_ptr - rd_ptr;
    assign empty  = (level == '0);
    assign full   = (level == DEPTH_L);
    assign do_pop = rd && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_wr  = push_q && (!full || do_pop);
    assign ovr_ev = push_q && full && !do_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr)  wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (do_pop) rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= shreg;
    end

    assign d          = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
    assign data_avail = !empty;
    assign fifo_level = 5'(level);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_ev)     frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
            if (ovr_ev)       overrun   <= 1'b1;
            else if (clr_err) overrun   <= 1'b0;
        end
    end

`ifdef LISA_RX_BREAK_DET_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           break_det <= 1'b0;
        else if (break_ev) break_det <= 1'b1;
        else if (clr_err)  break_det <= 1'b0;
    end
`else
    assign break_det = 1'b0;
`endif

endmodule

// File: tb/tb_lisa_rx_os_fifo.sv
// Self-checking bench for lisa_rx_os_fifo: directed table, corner sequences, random frames vs queue model.
module tb_lisa_rx_os_fifo;
    localparam int DEPTH   = 4;
    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_ref = 1'b0;
    logic       rxd = 1'b1;
    logic       rd = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] d;
    logic       data_avail;
    logic [4:0] fifo_level;
    logic       frame_err, overrun, break_det;

    int errors = 0;
    int checks = 0;

    logic [7:0] mq[$];
    logic       m_fe = 1'b0, m_ovr = 1'b0, m_brk = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         pops;
        logic       clr;
        int         exp_level;
        logic [7:0] exp_head;
        logic       exp_fe;
        logic       exp_ovr;
    } vec_t;
    vec_t tbl [9];

    lisa_rx_os_fifo #(.FIFO_DEPTH(DEPTH), .OVERSAMPLE(16)) dut (
        .clk(clk), .rst(rst), .baud_ref(baud_ref), .rxd(rxd), .rd(rd), .clr_err(clr_err),
        .d(d), .data_avail(data_avail), .fifo_level(fifo_level),
        .frame_err(frame_err), .overrun(overrun), .break_det(break_det)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(negedge clk);
            baud_ref = 1'b1;
            @(negedge clk);
            baud_ref = 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_b, input int gap_bits);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_b);
        rxd = 1'b1;
        repeat (gap_bits * BIT_CLK) @(negedge clk);
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop_b);
        if (stop_b) begin
            if (mq.size() < DEPTH) mq.push_back(b);
            else                   m_ovr = 1'b1;
        end else begin
`ifdef LISA_RX_BREAK_DET_EN
            if (b == 8'h00) m_brk = 1'b1;
            else            m_fe  = 1'b1;
`else
            m_fe = 1'b1;
`endif
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_level"}, int'(fifo_level), mq.size());
        chk({tag, "_avail"}, int'(data_avail), (mq.size() > 0) ? 1 : 0);
        if (mq.size() > 0) chk({tag, "_head"}, int'(d), int'(mq[0]));
        chk({tag, "_frame_err"}, int'(frame_err), int'(m_fe));
        chk({tag, "_overrun"}, int'(overrun), int'(m_ovr));
        chk({tag, "_break"}, int'(break_det), int'(m_brk));
    endtask

    task automatic clear_model();
        mq.delete();
        m_fe  = 1'b0;
        m_ovr = 1'b0;
        m_brk = 1'b0;
    endtask

    initial begin
        tbl[0] = '{8'h3C, 1'b0, 0, 1'b1, 0, 8'h00, 1'b1, 1'b0};
        tbl[1] = '{8'h5A, 1'b1, 0, 1'b0, 1, 8'h5A, 1'b0, 1'b0};
        tbl[2] = '{8'hC3, 1'b1, 0, 1'b0, 2, 8'h5A, 1'b0, 1'b0};
        tbl[3] = '{8'hFF, 1'b1, 0, 1'b0, 3, 8'h5A, 1'b0, 1'b0};
        tbl[4] = '{8'h00, 1'b1, 0, 1'b0, 4, 8'h5A, 1'b0, 1'b0};
        tbl[5] = '{8'h7E, 1'b1, 0, 1'b1, 4, 8'h5A, 1'b0, 1'b1};
        tbl[6] = '{8'h81, 1'b0, 2, 1'b1, 4, 8'h5A, 1'b1, 1'b0};
        tbl[7] = '{8'h99, 1'b1, 3, 1'b0, 3, 8'hFF, 1'b0, 1'b0};
        tbl[8] = '{8'h12, 1'b1, 1, 1'b0, 1, 8'h12, 1'b0, 1'b0};

        repeat (5) @(negedge clk);
        chk("reset_d", int'(d), 0);
        rst = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        check_model("reset");
        chk("reset_d_idle", int'(d), 0);

        // single byte, show-ahead, pop
        send_frame(8'hA5, 1'b1, 1);
        model_frame(8'hA5, 1'b1);
        check_model("single");
        pulse_rd();
        void'(mq.pop_front());
        chk("single_avail_after_rd", int'(data_avail), 0);
        pulse_rd();
        chk("empty_rd_level", int'(fifo_level), 0);

        for (int i = 0; i < 9; i++) begin
            send_frame(tbl[i].data, tbl[i].stop, 1);
            chk($sformatf("tbl%0d_level", i), int'(fifo_level), tbl[i].exp_level);
            chk($sformatf("tbl%0d_avail", i), int'(data_avail), (tbl[i].exp_level > 0) ? 1 : 0);
            if (tbl[i].exp_level > 0) chk($sformatf("tbl%0d_head", i), int'(d), int'(tbl[i].exp_head));
            chk($sformatf("tbl%0d_frame_err", i), int'(frame_err), int'(tbl[i].exp_fe));
            chk($sformatf("tbl%0d_overrun", i), int'(overrun), int'(tbl[i].exp_ovr));
            for (int k = 0; k < tbl[i].pops; k++) pulse_rd();
            if (tbl[i].clr) begin
                pulse_clr();
                chk($sformatf("tbl%0d_clr_fe", i), int'(frame_err), 0);
                chk($sformatf("tbl%0d_clr_ovr", i), int'(overrun), 0);
            end
        end
        chk("tbl_end_level", int'(fifo_level), 0);
        clear_model();

        // back-to-back frames into a 4-deep FIFO
        send_frame(8'h01, 1'b1, 0);
        send_frame(8'h02, 1'b1, 0);
        send_frame(8'h03, 1'b1, 0);
        send_frame(8'h04, 1'b1, 0);
        send_frame(8'h55, 1'b1, 1);
        for (int i = 1; i <= 4; i++) model_frame(8'(i), 1'b1);
        model_frame(8'h55, 1'b1);
        check_model("b2b");
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("b2b_pop%0d", i), int'(d), i);
            pulse_rd();
            void'(mq.pop_front());
        end
        check_model("b2b_drained");
        pulse_clr();
        m_ovr = 1'b0;
        check_model("b2b_clr");

        // short low glitch must be rejected by the start-bit vote
        rxd = 1'b0;
        repeat (12) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        check_model("glitch");

        // long low: break (or framing error without break detection)
        rxd = 1'b0;
        repeat (12 * BIT_CLK) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        model_frame(8'h00, 1'b0);
        check_model("break");
        pulse_clr();
        clear_model();
        check_model("break_clr");
        send_frame(8'hE7, 1'b1, 1);
        model_frame(8'hE7, 1'b1);
        check_model("after_break");

        // reset in the middle of a frame with data and flags present
        send_frame(8'h6B, 1'b0, 1);
        model_frame(8'h6B, 1'b0);
        check_model("pre_rst");
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rst = 1'b1;
        @(negedge clk);
        clear_model();
        check_model("mid_rst");
        chk("mid_rst_d", int'(d), 0);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        send_frame(8'hD2, 1'b1, 1);
        model_frame(8'hD2, 1'b1);
        check_model("post_rst");

        for (int n = 0; n < 24; n++) begin
            logic [7:0] b;
            logic       sb;
            int         np;
            b  = 8'($urandom);
            if (n == 5) b = 8'h00;
            sb = ($urandom_range(0, 5) != 0) || (n == 5) ? (n != 5) : 1'b0;
            send_frame(b, sb, 1);
            model_frame(b, sb);
            check_model($sformatf("rnd%0d", n));
            np = $urandom_range(0, 2);
            for (int k = 0; k < np; k++) begin
                pulse_rd();
                if (mq.size() > 0) void'(mq.pop_front());
            end
            chk($sformatf("rnd%0d_level_after_pop", n), int'(fifo_level), mq.size());
            if ($urandom_range(0, 3) == 0) begin
                pulse_clr();
                m_fe  = 1'b0;
                m_ovr = 1'b0;
                m_brk = 1'b0;
                check_model($sformatf("rnd%0d_clr", n));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
